// File: rtl/dpmem_port_master.sv
// dpmem_port_master
// Initiator for one port of a dual-port memory. It takes one read or write
// request at a time over a valid/ready handshake, drives the memory port for
// one cycle per attempt, and returns a response over a second valid/ready
// handshake. Read data is captured one cycle after the read edge. When the
// port is the low-priority side, an attempt flagged by `collision` is
// reissued, up to MAX_RETRY extra times, before an error response is given.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   reqValid/reqReady                 request handshake
//   reqWe, reqAddr, reqData           request type, address, write data
//   rspValid/rspReady                 response handshake
//   rspWe, rspData, rspErr            echoed type, read data, retries exhausted
//   memEn, memWEn, memAddr, memDIn    memory port drive (all registered)
//   memDOut                           memory read data (one-cycle latency)
//   collision                         memory collision flag
module dpmem_port_master #(
   parameter int addrW     = 8,
   parameter int dataW     = 16,
   parameter int LOW_PRIO  = 0,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reqValid,
   output logic             reqReady,
   input  logic             reqWe,
   input  logic [addrW-1:0] reqAddr,
   input  logic [dataW-1:0] reqData,
   output logic             rspValid,
   input  logic             rspReady,
   output logic             rspWe,
   output logic [dataW-1:0] rspData,
   output logic             rspErr,
   output logic             memEn,
   output logic             memWEn,
   output logic [addrW-1:0] memAddr,
   output logic [dataW-1:0] memDIn,
   input  logic [dataW-1:0] memDOut,
   input  logic             collision
);

   // A zero-retry configuration still needs a one-bit counter.
   localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);
   localparam bit LOW_PRIO_B = (LOW_PRIO != 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] retry_q,     retry_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_we_q,    rsp_we_d;
   logic [dataW-1:0] rsp_data_q,  rsp_data_d;
   logic             rsp_err_q,   rsp_err_d;
   logic             mem_en_q,    mem_en_d;
   logic             mem_wen_q,   mem_wen_d;
   logic [addrW-1:0] mem_addr_q,  mem_addr_d;
   logic [dataW-1:0] mem_din_q,   mem_din_d;
   logic             coll_hit_s;

   // Collisions only matter on the losing port.
   assign coll_hit_s = LOW_PRIO_B & collision;

   // Next-state and next-output computation for the request/response FSM.
   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      mem_en_d    = mem_en_q;
      mem_wen_d   = mem_wen_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      case (state_q)
         S_IDLE: begin
            if (reqValid && req_ready_q) begin
               // Address and write data are held in the memory-port
               // registers; the request type is held in rsp_we_q.
               state_d     = S_ISSUE;
               retry_d     = '0;
               req_ready_d = 1'b0;
               rsp_we_d    = reqWe;
               rsp_data_d  = {dataW{1'b0}};
               rsp_err_d   = 1'b0;
               mem_en_d    = 1'b1;
               mem_wen_d   = reqWe;
               mem_addr_d  = reqAddr;
               mem_din_d   = reqData;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (coll_hit_s) begin
               if (retry_q < RETRY_LIMIT) begin
                  // Reissue with unchanged port signals.
                  retry_d = retry_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  state_d     = S_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = {dataW{1'b0}};
                  mem_en_d    = 1'b0;
                  mem_wen_d   = 1'b0;
               end
            end else if (rsp_we_q) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               mem_en_d    = 1'b0;
               mem_wen_d   = 1'b0;
            end else begin
               state_d   = S_CAPTURE;
               mem_en_d  = 1'b0;
               mem_wen_d = 1'b0;
            end
         end
         S_CAPTURE: begin
            state_d     = S_RESP;
            rsp_data_d  = memDOut;
            rsp_valid_d = 1'b1;
         end
         S_RESP: begin
            if (rspReady) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d     = S_IDLE;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            mem_en_d    = 1'b0;
            mem_wen_d   = 1'b0;
         end
      endcase
   end

   // State and registered-output flops; reset returns everything to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         retry_q     <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_data_q  <= {dataW{1'b0}};
         rsp_err_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= {addrW{1'b0}};
         mem_din_q   <= {dataW{1'b0}};
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         mem_en_q    <= mem_en_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
      end
   end

   assign reqReady = req_ready_q;
   assign rspValid = rsp_valid_q;
   assign rspWe    = rsp_we_q;
   assign rspData  = rsp_data_q;
   assign rspErr   = rsp_err_q;
   assign memEn    = mem_en_q;
   assign memWEn   = mem_wen_q;
   assign memAddr  = mem_addr_q;
   assign memDIn   = mem_din_q;

endmodule

// File: tb/tb_dpmem_port_master.sv
// Bench for dpmem_port_master: instance 0 is a high-priority port
// (collision ignored), instance 1 a low-priority port with MAX_RETRY = 3.
// Each instance has its own memory model; the low-priority memory drops a
// write on a colliding cycle. Expected responses are queued at issue time
// and compared by a monitor on each response handshake.
module tb_dpmem_port_master;

   localparam int MAXR = 3;

   typedef struct {
      logic        we;
      logic [15:0] data;
      logic        err;
      int          lat;
      int          att;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [7:0]  req_addr  [2];
   logic [15:0] req_data  [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic        rsp_we    [2];
   logic [15:0] rsp_data  [2];
   logic        rsp_err   [2];
   logic        mem_en    [2];
   logic        mem_wen   [2];
   logic [7:0]  mem_addr  [2];
   logic [15:0] mem_din   [2];
   logic [15:0] mem_dout  [2];
   logic        collision [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int en_cnt    [2] = '{0, 0};
   int base      [2] = '{0, 0};
   int coll_k    [2] = '{0, 0};
   int bp_cycles [2] = '{0, 0};
   bit rand_bp = 1'b0;

   logic [15:0] mem     [2][256];
   logic [15:0] ref_mem [2][256];
   exp_t q0[$];
   exp_t q1[$];

   dpmem_port_master #(.addrW(8), .dataW(16), .LOW_PRIO(0), .MAX_RETRY(MAXR)) u_hi (
      .clk(clk), .rst_n(rst_n),
      .reqValid(req_valid[0]), .reqReady(req_ready[0]), .reqWe(req_we[0]),
      .reqAddr(req_addr[0]), .reqData(req_data[0]),
      .rspValid(rsp_valid[0]), .rspReady(rsp_ready[0]), .rspWe(rsp_we[0]),
      .rspData(rsp_data[0]), .rspErr(rsp_err[0]),
      .memEn(mem_en[0]), .memWEn(mem_wen[0]), .memAddr(mem_addr[0]),
      .memDIn(mem_din[0]), .memDOut(mem_dout[0]), .collision(collision[0]));

   dpmem_port_master #(.addrW(8), .dataW(16), .LOW_PRIO(1), .MAX_RETRY(MAXR)) u_lo (
      .clk(clk), .rst_n(rst_n),
      .reqValid(req_valid[1]), .reqReady(req_ready[1]), .reqWe(req_we[1]),
      .reqAddr(req_addr[1]), .reqData(req_data[1]),
      .rspValid(rsp_valid[1]), .rspReady(rsp_ready[1]), .rspWe(rsp_we[1]),
      .rspData(rsp_data[1]), .rspErr(rsp_err[1]),
      .memEn(mem_en[1]), .memWEn(mem_wen[1]), .memAddr(mem_addr[1]),
      .memDIn(mem_din[1]), .memDOut(mem_dout[1]), .collision(collision[1]));

   // Collision is high for the first coll_k memEn cycles of a request
   // (and stays high outside ISSUE while that count is not reached).
   assign collision[0] = (en_cnt[0] - base[0]) < coll_k[0];
   assign collision[1] = (en_cnt[1] - base[1]) < coll_k[1];

   initial forever #5 clk = ~clk;

   // Cycle counter and per-port count of memEn cycles.
   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      for (int p = 0; p < 2; p++)
         if (mem_en[p] === 1'b1) en_cnt[p] <= en_cnt[p] + 1;
   end

   // Memory models: one-cycle read latency; losing write is dropped.
   initial begin
      for (int p = 0; p < 2; p++) begin
         mem_dout[p] = 16'h0000;
         for (int a = 0; a < 256; a++) mem[p][a] = 16'h0000;
      end
      forever begin
         @(posedge clk);
         for (int p = 0; p < 2; p++) begin
            if (mem_en[p] === 1'b1) begin
               if (mem_wen[p] === 1'b1) begin
                  if (!(p == 1 && collision[1])) mem[p][mem_addr[p]] <= mem_din[p];
               end else begin
                  mem_dout[p] <= mem[p][mem_addr[p]];
               end
            end
         end
      end
   end

   // Response-ready driver: directed hold of bp_cycles, else random or 1.
   initial begin
      int vcnt [2];
      vcnt = '{0, 0};
      rsp_ready[0] = 1'b1;
      rsp_ready[1] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int p = 0; p < 2; p++) begin
            if (rsp_valid[p] === 1'b1) vcnt[p]++;
            else vcnt[p] = 0;
            if (bp_cycles[p] > 0) rsp_ready[p] = (vcnt[p] > bp_cycles[p]);
            else if (rand_bp) rsp_ready[p] = ($urandom_range(0, 2) != 0);
            else rsp_ready[p] = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: checks hold behaviour in RESP and scores each response.
   initial begin
      bit prev_valid [2];
      bit chk_idle   [2];
      int acc_cyc    [2];
      int v_cyc      [2];
      exp_t e;
      prev_valid = '{0, 0};
      chk_idle   = '{0, 0};
      acc_cyc    = '{0, 0};
      v_cyc      = '{0, 0};
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (rst_n !== 1'b1) begin
               prev_valid[p] = 1'b0;
               chk_idle[p]   = 1'b0;
            end else begin
               if (chk_idle[p]) begin
                  chk("idle_after_rsp", req_ready[p], 1);
                  chk_idle[p] = 1'b0;
               end
               if (req_valid[p] && req_ready[p]) acc_cyc[p] = cyc;
               if (rsp_valid[p] && !prev_valid[p]) v_cyc[p] = cyc;
               if (rsp_valid[p] === 1'b1) begin
                  chk("resp_mem_en_low", mem_en[p], 0);
                  chk("resp_req_ready_low", req_ready[p], 0);
                  if (prev_valid[p] && p == 0 && q0.size() > 0) chk("hold_data", rsp_data[p], q0[0].data);
                  if (prev_valid[p] && p == 1 && q1.size() > 0) chk("hold_data", rsp_data[p], q1[0].data);
                  if (rsp_ready[p] === 1'b1) begin
                     if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                        chk("unexpected_rsp", 1, 0);
                     end else begin
                        if (p == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk("rsp_we", rsp_we[p], e.we);
                        chk("rsp_data", rsp_data[p], e.data);
                        chk("rsp_err", rsp_err[p], e.err);
                        chk("rsp_latency", v_cyc[p] - acc_cyc[p], e.lat);
                        chk("mem_en_cycles", en_cnt[p] - base[p], e.att);
                     end
                     chk_idle[p] = 1'b1;
                  end
               end
               prev_valid[p] = rsp_valid[p];
            end
         end
      end
   end

   // Issue one request on port p; the expectation comes from the access
   // rules: the losing port needs k+1 attempts, giving up after MAXR+1.
   task automatic issue(input int p, input logic we, input logic [7:0] addr,
                        input logic [15:0] data, input int k);
      exp_t e;
      int   att;
      bit   ok;
      int   n = 0;
      @(posedge clk);
      #1;
      while (req_ready[p] !== 1'b1 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (req_ready[p] !== 1'b1) begin
         chk("req_ready_timeout", 0, 1);
      end else begin
         if (p == 0) begin
            att = 1; ok = 1'b1;
         end else if (k <= MAXR) begin
            att = k + 1; ok = 1'b1;
         end else begin
            att = MAXR + 1; ok = 1'b0;
         end
         e.we   = we;
         e.err  = !ok;
         e.data = (we || !ok) ? 16'h0000 : ref_mem[p][addr];
         e.att  = att;
         e.lat  = 1 + att + ((!we && ok) ? 1 : 0);
         if (we && ok) ref_mem[p][addr] = data;
         if (p == 0) q0.push_back(e);
         else q1.push_back(e);
         base[p]      = en_cnt[p];
         coll_k[p]    = k;
         req_we[p]    = we;
         req_addr[p]  = addr;
         req_data[p]  = data;
         req_valid[p] = 1'b1;
         @(posedge clk);
         #1;
         req_valid[p] = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk("drain", q0.size() + q1.size(), 0);
   endtask

   initial begin
      int ks [9];
      ks = '{0, 0, 0, 1, 2, 3, 4, 7, 100};
      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) begin
         req_valid[p] = 1'b0;
         req_we[p]    = 1'b0;
         req_addr[p]  = 8'h00;
         req_data[p]  = 16'h0000;
         for (int a = 0; a < 256; a++) ref_mem[p][a] = 16'h0000;
      end
      repeat (3) @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         chk("rst_req_ready", req_ready[p], 1);
         chk("rst_rsp_valid", rsp_valid[p], 0);
         chk("rst_rsp_we", rsp_we[p], 0);
         chk("rst_rsp_data", rsp_data[p], 0);
         chk("rst_rsp_err", rsp_err[p], 0);
         chk("rst_mem_en", mem_en[p], 0);
         chk("rst_mem_wen", mem_wen[p], 0);
         chk("rst_mem_addr", mem_addr[p], 0);
         chk("rst_mem_din", mem_din[p], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Write then read, and back-pressured read.
      issue(0, 1'b1, 8'h01, 16'h0002, 0);
      issue(0, 1'b0, 8'h01, 16'h0000, 0);
      issue(0, 1'b1, 8'h03, 16'h0004, 0);
      drain();
      bp_cycles[0] = 5;
      issue(0, 1'b0, 8'h03, 16'h0000, 0);
      drain();
      bp_cycles[0] = 0;

      // Low-priority port: single retry, then exhausted retries.
      issue(1, 1'b1, 8'h05, 16'h0008, 1);
      issue(1, 1'b0, 8'h05, 16'h0000, 100);
      issue(1, 1'b0, 8'h05, 16'h0000, 0);
      // High-priority port ignores a stuck collision.
      issue(0, 1'b1, 8'h05, 16'h0007, 100);
      drain();

      // Reset while the read is in CAPTURE.
      issue(0, 1'b0, 8'h01, 16'h0000, 0);
      @(posedge clk);
      #2;
      chk("capture_mem_en", mem_en[0], 0);
      chk("capture_rsp_valid", rsp_valid[0], 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_mem_en", mem_en[0], 0);
      chk("async_rst_req_ready", req_ready[0], 1);
      chk("async_rst_rsp_valid", rsp_valid[0], 0);
      chk("async_rst_rsp_data", rsp_data[0], 0);
      chk("async_rst_mem_addr", mem_addr[0], 0);
      q0.delete();
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid[0], 0);
      end
      rst_n = 1'b1;
      #1;
      chk("post_rst_req_ready", req_ready[0], 1);
      issue(0, 1'b0, 8'h01, 16'h0000, 0);
      drain();

      // Randomized traffic on both ports with random back-pressure.
      rand_bp = 1'b1;
      for (int i = 0; i < 80; i++) begin
         issue($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
               16'($urandom), ks[$urandom_range(0, 8)]);
      end
      drain();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
